// File: rtl/flipflop_pkg.sv
// flipflop_pkg: shared defaults and width helper for the flip-flop pipeline.
package flipflop_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int MAX_DEPTH = 16;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/flipflop_stage.sv
// flipflop_stage: one data+valid register with async reset, sync clear and enable.
module flipflop_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      d_out <= RESET_VAL;
      v_out <= 1'b0;
    end else if (clr) begin
      d_out <= RESET_VAL;
      v_out <= 1'b0;
    end else if (en) begin
      d_out <= d_in;
      v_out <= v_in;
    end
endmodule

// File: rtl/flipflop_pipe.sv
// flipflop_pipe: DEPTH-stage data/valid shift pipeline with a selectable tap and valid count.
module flipflop_pipe
  import flipflop_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              en,
  input  logic                              clr,
  input  logic [WIDTH-1:0]                  qin,
  input  logic                              vin,
  input  logic [sel_width(DEPTH)-1:0]       tap_sel,
  output logic [WIDTH-1:0]                  qout,
  output logic                              vout,
  output logic [WIDTH-1:0]                  tap_q,
  output logic                              tap_v,
  output logic [sel_width(DEPTH+1)-1:0]     count
);
  localparam int CW = sel_width(DEPTH + 1);
  // Element 0 is the pipeline input; element k+1 is the output of stage k.
  logic [WIDTH-1:0] d [DEPTH+1];
  logic             v [DEPTH+1];
  assign d[0] = qin;
  assign v[0] = vin;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    flipflop_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
      .d_in(d[k]), .v_in(v[k]), .d_out(d[k+1]), .v_out(v[k+1])
    );
  end
  assign qout = d[DEPTH];
  assign vout = v[DEPTH];
  // Out-of-range selects fall through to the last stage.
  always_comb begin
    tap_q = d[DEPTH];
    tap_v = v[DEPTH];
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (32'(tap_sel) == k) begin
        tap_q = d[k+1];
        tap_v = v[k+1];
      end
      count = count + CW'(v[k+1]);
    end
  end
endmodule

// File: tb/tb_flipflop_pipe.sv
// tb_flipflop_pipe: directed checks of flipflop_pipe at DEPTH 4, 5, 1 and 16.
module tb_flipflop_pipe;
  logic        clk, reset_n, en, clr, vin;
  logic [31:0] qin;
  logic [3:0]  tap_sel;
  int errors = 0;
  int checks = 0;

  logic [7:0]  q4, t4;   logic v4, tv4;   logic [2:0] c4;
  logic [7:0]  q5, t5;   logic v5, tv5;   logic [2:0] c5;
  logic        q1, t1;   logic v1, tv1;   logic       c1;
  logic [31:0] q16, t16; logic v16, tv16; logic [4:0] c16;

  flipflop_pipe #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .qin(qin[7:0]), .vin(vin),
    .tap_sel(tap_sel[1:0]), .qout(q4), .vout(v4), .tap_q(t4), .tap_v(tv4), .count(c4));
  flipflop_pipe #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .qin(qin[7:0]), .vin(vin),
    .tap_sel(tap_sel[2:0]), .qout(q5), .vout(v5), .tap_q(t5), .tap_v(tv5), .count(c5));
  flipflop_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .qin(qin[0]), .vin(vin),
    .tap_sel(tap_sel[0]), .qout(q1), .vout(v1), .tap_q(t1), .tap_v(tv1), .count(c1));
  flipflop_pipe #(.WIDTH(32), .DEPTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .qin(qin), .vin(vin),
    .tap_sel(tap_sel), .qout(q16), .vout(v16), .tap_q(t16), .tap_v(tv16), .count(c16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int i);
    logic [3:0] p;
    p = 4'b1101;
    return (i >= 0 && i < 4) ? p[i] : 1'b0;
  endfunction

  function automatic int cnt(input int n, input int d);
    int s;
    s = 0;
    for (int j = 0; j < d; j++) s += int'(pat(n - 1 - j));
    return s;
  endfunction

  initial begin
    reset_n = 1'b0; en = 1'b0; clr = 1'b0; vin = 1'b0; qin = '0; tap_sel = '0;
    #2;
    chk("rst_qout", q4, 0);
    chk("rst_vout", v4, 0);
    chk("rst_count", c4, 0);
    chk("rst_tapv", tv4, 0);
    chk("rst_count16", c16, 0);
    tick();
    reset_n = 1'b1;
    en = 1'b1; vin = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      qin = 32'(i);
      tick();
      chk("lat_count", c4, (i < 4) ? i : 4);
      chk("lat_vout", v4, (i >= 4) ? 1 : 0);
      chk("lat_qout", q4, (i >= 4) ? i - 3 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      qin = 32'(8'h44 - 8'h11 * i);
      tick();
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tap_sel = 4'(i);
      #1;
      chk("tap_q", t4, 8'h11 * (i + 1));
      chk("tap_v", tv4, 1);
    end
    tap_sel = 4'd7;
    #1;
    chk("tap5_clamp_q", t5, 7);
    chk("tap5_clamp_v", tv5, 1);
    chk("tap5_qout", q5, 7);
    tap_sel = '0; en = 1'b1; clr = 1'b1; vin = 1'b1; qin = 32'h99;
    tick();
    clr = 1'b0; en = 1'b0;
    chk("clr_vout", v4, 0);
    chk("clr_count", c4, 0);
    chk("clr_qout", q4, 0);
    chk("clr_tapq", t4, 0);
    chk("clr_tapv", tv4, 0);
    en = 1'b1; vin = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      qin = 32'(i);
      tick();
    end
    en = 1'b0; qin = 32'h77;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_count", c4, 3);
      chk("stall_vout", v4, 0);
      chk("stall_qout", q4, 0);
      chk("stall_tapq", t4, 3);
    end
    en = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      qin = 32'(i);
      tick();
      chk("resume_qout", q4, i - 3);
      chk("resume_vout", v4, 1);
      chk("resume_count", c4, 4);
    end
    vin = 1'b0; qin = 32'h5;
    tick();
    vin = 1'b1;
    for (int i = 'hA; i <= 'hC; i++) begin
      qin = 32'(i);
      tick();
    end
    en = 1'b0;
    chk("pre_count", c4, 3);
    chk("pre_qout", q4, 5);
    chk("pre_tapq", t4, 8'hC);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_qout", q4, 0);
    chk("arst_vout", v4, 0);
    chk("arst_count", c4, 0);
    chk("arst_tapq", t4, 0);
    chk("arst_tapv", tv4, 0);
    #2 reset_n = 1'b1;
    en = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      vin = pat(n - 1);
      qin = 32'(n);
      tick();
      chk("bub4_vout", v4, pat(n - 4));
      chk("bub4_count", c4, cnt(n, 4));
      chk("bub4_qout", q4, (n >= 4) ? n - 3 : 0);
      chk("bub1_vout", v1, pat(n - 1));
      chk("bub1_count", c1, pat(n - 1));
      chk("bub1_qout", q1, n[0]);
      chk("bub1_tapq", t1, n[0]);
      chk("bub16_vout", v16, pat(n - 16));
      chk("bub16_count", c16, cnt(n, 16));
      chk("bub16_qout", q16, (n >= 16) ? n - 15 : 0);
      chk("bub16_tapv", tv16, pat(n - 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
